// File: rtl/pipelined_accumulator_pkg.sv
// Shared helpers for the pipelined vector accumulator: lane count,
// sign extension and the saturating add used when saturation is built in.
package pipelined_accumulator_pkg;

    localparam int EXT_W = 64;

    function automatic int num_lanes(input int log2_no_in);
        return 1 << log2_no_in;
    endfunction

    // Sign-extends the low 'w' bits of val to EXT_W bits.
    function automatic logic signed [EXT_W-1:0] sign_ext(input logic [EXT_W-1:0] val,
                                                         input int w);
        logic signed [EXT_W-1:0] t;
        t = $signed(val << (EXT_W - w));
        return t >>> (EXT_W - w);
    endfunction

    // Adds two already sign-extended operands and clamps to a signed w-bit range.
    function automatic logic signed [EXT_W-1:0] sat_add(input logic signed [EXT_W-1:0] a,
                                                        input logic signed [EXT_W-1:0] b,
                                                        input int w);
        logic signed [EXT_W-1:0] s;
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/pipelined_vec_accumulator_level.sv
// One registered level of the adder tree: M inputs reduced to M/2 pairwise
// sums, each wrapped to W bits.
module pa_adder_level
    import pipelined_accumulator_pkg::*;
#(
    parameter int M = 2,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M*W-1:0]       i_data,
    output logic [(M/2)*W-1:0]   o_data
);

    logic [(M/2)*W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            for (int j = 0; j < M/2; j++) begin
                r_sum[j*W +: W] <= i_data[(2*j)*W +: W] + i_data[(2*j+1)*W +: W];
            end
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/pipelined_vec_accumulator.sv
// Registered binary adder tree feeding a running accumulator; new_sum restarts
// the total. Define PIPELINED_ACC_SATURATE_EN to saturate the accumulator add.
module pipelined_vec_accumulator
    import pipelined_accumulator_pkg::*;
#(
    parameter int IN_BITWIDTH  = 16,
    parameter int OUT_BITWIDTH = 16,
    parameter int LOG2_NO_IN   = 2
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             new_sum,
    input  logic [num_lanes(LOG2_NO_IN)*IN_BITWIDTH-1:0]     data_in,
    output logic [OUT_BITWIDTH-1:0]                          data_out
);

    localparam int N = num_lanes(LOG2_NO_IN);

    // All tree levels packed back to back: level k starts at lane 2N - 2*(N>>k).
    logic [(2*N-1)*OUT_BITWIDTH-1:0] w_tree;
    logic signed [OUT_BITWIDTH-1:0]  w_tree_sum;
    logic signed [OUT_BITWIDTH-1:0]  w_acc_next;
    logic signed [OUT_BITWIDTH-1:0]  r_acc;
    logic                            w_ns_d;

    for (genvar i = 0; i < N; i++) begin : g_sext
        assign w_tree[i*OUT_BITWIDTH +: OUT_BITWIDTH] =
            OUT_BITWIDTH'(sign_ext(EXT_W'(data_in[i*IN_BITWIDTH +: IN_BITWIDTH]), IN_BITWIDTH));
    end

    for (genvar k = 1; k <= LOG2_NO_IN; k++) begin : g_level
        localparam int M_IN    = N >> (k - 1);
        localparam int OFF_IN  = 2*N - 2*M_IN;
        localparam int OFF_OUT = 2*N - M_IN;
        pa_adder_level #(
            .M (M_IN),
            .W (OUT_BITWIDTH)
        ) u_level (
            .clk    (clk),
            .rst    (rst),
            .i_data (w_tree[OFF_IN*OUT_BITWIDTH  +: M_IN*OUT_BITWIDTH]),
            .o_data (w_tree[OFF_OUT*OUT_BITWIDTH +: (M_IN/2)*OUT_BITWIDTH])
        );
    end

    assign w_tree_sum = w_tree[(2*N-2)*OUT_BITWIDTH +: OUT_BITWIDTH];

    if (LOG2_NO_IN == 0) begin : g_ns_direct
        assign w_ns_d = new_sum;
    end else begin : g_ns_pipe
        logic [LOG2_NO_IN-1:0] r_ns_pipe;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ns_pipe <= '0;
            end else begin
                r_ns_pipe[0] <= new_sum;
                for (int j = 1; j < LOG2_NO_IN; j++) begin
                    r_ns_pipe[j] <= r_ns_pipe[j-1];
                end
            end
        end
        assign w_ns_d = r_ns_pipe[LOG2_NO_IN-1];
    end

`ifdef PIPELINED_ACC_SATURATE_EN
    assign w_acc_next = OUT_BITWIDTH'(sat_add(EXT_W'(r_acc), EXT_W'(w_tree_sum), OUT_BITWIDTH));
`else
    assign w_acc_next = r_acc + w_tree_sum;
`endif

    // Accumulator stage: a restarting vector replaces the old total outright.
    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (w_ns_d)
            r_acc <= w_tree_sum;
        else
            r_acc <= w_acc_next;
    end

    assign data_out = r_acc;

endmodule

// File: tb/tb_pipelined_vec_accumulator.sv
// Bench for pipelined_vec_accumulator: a 4-lane and a 1-lane instance driven
// together, compared every cycle against a delay-line model plus directed values.
module tb_pipelined_vec_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_sum = 1'b0;
    logic [31:0] data_in = '0;
    logic [15:0] dout2;
    logic [15:0] dout0;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_acc2 = '0;
    logic [15:0] m_acc0 = '0;
    logic [15:0] q_sum[$];
    bit          q_ns[$];

    always #5 clk = ~clk;

    pipelined_vec_accumulator #(
        .IN_BITWIDTH (8),
        .OUT_BITWIDTH(16),
        .LOG2_NO_IN  (2)
    ) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .new_sum (new_sum),
        .data_in (data_in),
        .data_out(dout2)
    );

    pipelined_vec_accumulator #(
        .IN_BITWIDTH (8),
        .OUT_BITWIDTH(16),
        .LOG2_NO_IN  (0)
    ) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .new_sum (new_sum),
        .data_in (data_in[7:0]),
        .data_out(dout0)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_sum(input logic [31:0] v, input int lanes);
        int s = 0;
        for (int i = 0; i < lanes; i++) s += int'($signed(v[i*8 +: 8]));
        return 16'(s);
    endfunction

    function automatic logic [15:0] accum(input logic [15:0] acc, input bit ns, input logic [15:0] s);
        int t;
        if (ns) return s;
        t = int'($signed(acc)) + int'($signed(s));
`ifdef PIPELINED_ACC_SATURATE_EN
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`endif
        return 16'(t);
    endfunction

    // Model: the 4-lane total sees each vector two edges after sampling,
    // the 1-lane total sees it at the sampling edge.
    task automatic model_step();
        if (rst) begin
            m_acc2 = '0;
            m_acc0 = '0;
            q_sum = '{16'h0, 16'h0};
            q_ns  = '{1'b0, 1'b0};
        end else begin
            q_sum.push_back(lane_sum(data_in, 4));
            q_ns.push_back(new_sum);
            m_acc2 = accum(m_acc2, q_ns.pop_front(), q_sum.pop_front());
            m_acc0 = accum(m_acc0, new_sum, lane_sum(data_in, 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_l2", dout2, m_acc2);
        check("model_l0", dout0, m_acc0);
    endtask

    task automatic drive(input bit ns, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        new_sum = ns;
        data_in = {d, c, b, a};
        tick();
    endtask

    initial begin
        q_sum = '{16'h0, 16'h0};
        q_ns  = '{1'b0, 1'b0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("reset_l2", dout2, 16'h0000);
        check("reset_l0", dout0, 16'h0000);
        rst = 1'b0;

        drive(1, 1, 2, 3, 4);
        drive(0, 5, 6, 7, 8);
        drive(0, 0, 0, 0, 0);
        check("basic_10", dout2, 16'd10);
        drive(0, 0, 0, 0, 0);
        check("basic_36", dout2, 16'd36);
        drive(0, 0, 0, 0, 0);
        check("basic_hold", dout2, 16'd36);

        drive(1, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("restart_4", dout2, 16'd4);
        drive(1, 2, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        check("ns_run_a", dout2, 16'd2);
        drive(0, 0, 0, 0, 0);
        check("ns_run_b", dout2, 16'd2);
        drive(0, 0, 0, 0, 0);
        check("ns_run_c", dout2, 16'd2);

        drive(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drive(0, 8'h80, 8'h80, 8'h80, 8'h80);
        drive(0, 0, 0, 0, 0);
        check("sext_m4", dout2, 16'hFFFC);
        drive(0, 0, 0, 0, 0);
        check("sext_m516", dout2, 16'hFDFC);

        // 64 x 508 + 255 = 32767, then one more count crosses the top.
        drive(1, 127, 127, 127, 127);
        for (int i = 0; i < 63; i++) drive(0, 127, 127, 127, 127);
        drive(0, 127, 127, 1, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("wrap_max", dout2, 16'h7FFF);
        drive(0, 0, 0, 0, 0);
`ifdef PIPELINED_ACC_SATURATE_EN
        check("wrap_sat", dout2, 16'h7FFF);
`else
        check("wrap_min", dout2, 16'h8000);
`endif

        drive(1, 10, 10, 10, 10);
        drive(0, 20, 20, 20, 20);
        rst = 1'b1;
        drive(0, 30, 30, 30, 30);
        check("midrst_l2", dout2, 16'h0000);
        rst = 1'b0;
        drive(0, 1, 1, 1, 1);
        check("flush_zero", dout2, 16'h0000);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("post_rst_4", dout2, 16'd4);

        drive(1, 5, 0, 0, 0);
        check("degen_5", dout0, 16'd5);
        drive(0, 3, 0, 0, 0);
        check("degen_8", dout0, 16'd8);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
